// File: rtl/key_debouncer_pkg.sv
// Shared game timing constants for button conditioning at 65 MHz, plus the
// counter type used by every debouncer instance and the hold stage.
package key_debouncer_pkg;

    localparam int unsigned CNT_W = 26;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned DEBOUNCE_TIME_DEF = 650000;    // 10 ms
    localparam int unsigned REPEAT_DELAY_DEF  = 32500000;  // 0.5 s
    localparam int unsigned REPEAT_PERIOD_DEF = 6500000;   // 0.1 s
    localparam bit          REPEAT_EN_DEF     = 1'b1;

    // Terminal count for an interval of n cycles on the shared counter.
    function automatic cnt_t cnt_last(input int unsigned n);
        return CNT_W'(n - 32'd1);
    endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key conditioning bundle: raw key level in, debounced level and event pulses out.
interface key_debouncer_if;

    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_repeat;
    logic key_pulse;

    modport master (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_repeat,
        output key_pulse
    );

    modport slave (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_repeat,
        input  key_pulse
    );

endinterface

// File: rtl/key_debouncer_sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous inputs; synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Push-button conditioner: synchronise, debounce, and emit press / release /
// auto-repeat pulses plus the steady debounced level.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TIME = DEBOUNCE_TIME_DEF,
    parameter bit          REPEAT_EN     = REPEAT_EN_DEF,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input logic             clk,
    input logic             rst,
    key_debouncer_if.master key
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REPEAT,
        RELEASE_CHK
    } state_t;

    localparam cnt_t DEB_LAST = cnt_last(DEBOUNCE_TIME);
    localparam cnt_t DLY_LAST = cnt_last(REPEAT_DELAY);
    localparam cnt_t PER_LAST = cnt_last(REPEAT_PERIOD);
    localparam cnt_t CNT_MAX  = '1;

    logic   key_sync;
    state_t state, state_next;
    cnt_t   cnt, cnt_next;
    logic   level, level_next;
    logic   press, press_next;
    logic   release_q, release_next;
    logic   rpt, rpt_next;
    logic   pulse, pulse_next;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key.key_in),
        .q   (key_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            level     <= 1'b0;
            press     <= 1'b0;
            release_q <= 1'b0;
            rpt       <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            level     <= level_next;
            press     <= press_next;
            release_q <= release_next;
            rpt       <= rpt_next;
            pulse     <= pulse_next;
        end
    end

    // Next state, shared counter and next output values.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        level_next   = level;
        press_next   = 1'b0;
        release_next = 1'b0;
        rpt_next     = 1'b0;

        unique case (state)
            IDLE: begin
                if (key_sync) begin
                    state_next = PRESS_CHK;
                    cnt_next   = '0;
                end
            end
            PRESS_CHK: begin
                if (!key_sync) begin
                    state_next = IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    press_next = 1'b1;
                    level_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!key_sync) begin
                    state_next = RELEASE_CHK;
                    cnt_next   = '0;
                end else if (REPEAT_EN && cnt == DLY_LAST) begin
                    state_next = REPEAT;
                    cnt_next   = '0;
                    rpt_next   = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!key_sync) begin
                    state_next = RELEASE_CHK;
                    cnt_next   = '0;
                end else if (cnt == PER_LAST) begin
                    cnt_next = '0;
                    rpt_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RELEASE_CHK: begin
                // A bounce back to pressed resumes holding; the repeat delay restarts.
                if (key_sync) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    release_next = 1'b1;
                    level_next   = 1'b0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        pulse_next = press_next | rpt_next;
    end

    assign key.key_level   = level;
    assign key.key_press   = press;
    assign key.key_release = release_q;
    assign key.key_repeat  = rpt;
    assign key.key_pulse   = pulse;

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench: a run-length/timestamp model predicts events for a
// repeat-enabled and a repeat-disabled instance driven by the same key.
module tb_key_debouncer;

    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    localparam int K_PRESS   = 1;
    localparam int K_RELEASE = 2;
    localparam int K_REPEAT  = 3;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    typedef struct {
        bit s1;
        bit s2;
        bit prev;
        int run;
        bit lvl;
        int hold;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key = 1'b0;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rep1     = 0;
    mdl_t m [2];
    bit   exp_lvl [2];
    ev_t  q0 [$];
    ev_t  q1 [$];

    always #5 clk = ~clk;

    key_debouncer_if kif0 ();
    key_debouncer_if kif1 ();

    assign kif0.key_in = key;
    assign kif1.key_in = key;

    key_debouncer #(
        .DEBOUNCE_TIME (DEB),
        .REPEAT_EN     (1'b1),
        .REPEAT_DELAY  (DLY),
        .REPEAT_PERIOD (PER)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .key (kif0)
    );

    key_debouncer #(
        .DEBOUNCE_TIME (DEB),
        .REPEAT_EN     (1'b0),
        .REPEAT_DELAY  (DLY),
        .REPEAT_PERIOD (PER)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .key (kif1)
    );

    function automatic string kname(input int k);
        case (k)
            K_PRESS:   return "press";
            K_RELEASE: return "release";
            K_REPEAT:  return "repeat";
            default:   return "none";
        endcase
    endfunction

    task automatic push(input int d, input int kind);
        ev_t e;
        e.cyc  = cyc;
        e.kind = kind;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Reference: an event fires when the synchronised level has been steady for
    // DEB+1 consecutive edges; repeats are timed from the last start of holding.
    task automatic step_model(input int d, input bit en);
        bit s;
        int dt;
        if (rst) begin
            m[d]       = '{default: 0};
            exp_lvl[d] = 1'b0;
            return;
        end
        s = m[d].s2;
        if (m[d].run != 0 && s == m[d].prev) m[d].run++;
        else                                 m[d].run = 1;
        m[d].prev = s;
        if (!m[d].lvl && s && m[d].run == DEB + 1) begin
            m[d].lvl  = 1'b1;
            m[d].hold = cyc;
            push(d, K_PRESS);
        end else if (m[d].lvl && !s && m[d].run == DEB + 1) begin
            m[d].lvl = 1'b0;
            push(d, K_RELEASE);
        end else if (m[d].lvl && s) begin
            if (m[d].run == 1) begin
                m[d].hold = cyc;
            end else if (en) begin
                dt = cyc - m[d].hold;
                if (dt >= DLY && (dt - DLY) % PER == 0) push(d, K_REPEAT);
            end
        end
        m[d].s2    = m[d].s1;
        m[d].s1    = key;
        exp_lvl[d] = m[d].lvl;
    endtask

    always @(posedge clk) begin
        cyc++;
        step_model(0, 1'b1);
        step_model(1, 1'b0);
    end

    task automatic mon(input int d, input logic lv, input logic pr, input logic rl,
                       input logic rp, input logic pu);
        ev_t h;
        bit  have;
        int  nhi;
        int  kind;
        checks++;
        if (pu !== (pr | rp)) begin
            failures++;
            $display("FAIL pulse_or dut%0d cyc=%0d got=%b exp=%b", d, cyc, pu, pr | rp);
        end
        checks++;
        if (lv !== exp_lvl[d]) begin
            failures++;
            $display("FAIL level dut%0d cyc=%0d got=%b exp=%b", d, cyc, lv, exp_lvl[d]);
        end
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) h = (d == 0) ? q0[0] : q1[0];
        nhi = int'(pr === 1'b1) + int'(rl === 1'b1) + int'(rp === 1'b1);
        if (nhi != 0) begin
            kind = (pr === 1'b1) ? K_PRESS : (rl === 1'b1) ? K_RELEASE : K_REPEAT;
            if (d == 1 && rp === 1'b1) rep1++;
            checks++;
            if (nhi > 1) begin
                failures++;
                $display("FAIL exclusive dut%0d cyc=%0d got press=%b release=%b repeat=%b exp at most one",
                         d, cyc, pr, rl, rp);
            end
            checks++;
            if (!have) begin
                failures++;
                $display("FAIL unexpected dut%0d cyc=%0d got=%s exp=none", d, cyc, kname(kind));
            end else begin
                if (h.cyc != cyc || h.kind != kind) begin
                    failures++;
                    $display("FAIL event dut%0d got=%s@%0d exp=%s@%0d",
                             d, kname(kind), cyc, kname(h.kind), h.cyc);
                end
                if (d == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end else if (have && h.cyc <= cyc) begin
            checks++;
            failures++;
            $display("FAIL missed dut%0d cyc=%0d got=none exp=%s@%0d", d, cyc, kname(h.kind), h.cyc);
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, kif0.key_level, kif0.key_press, kif0.key_release, kif0.key_repeat, kif0.key_pulse);
        mon(1, kif1.key_level, kif1.key_press, kif1.key_release, kif1.key_repeat, kif1.key_pulse);
    end

    task automatic chk_zero(input string tag);
        logic [4:0] o0;
        logic [4:0] o1;
        o0 = {kif0.key_level, kif0.key_press, kif0.key_release, kif0.key_repeat, kif0.key_pulse};
        o1 = {kif1.key_level, kif1.key_press, kif1.key_release, kif1.key_repeat, kif1.key_pulse};
        checks++;
        if (o0 !== 5'b0) begin
            failures++;
            $display("FAIL %s dut0 outputs got=%b exp=00000", tag, o0);
        end
        checks++;
        if (o1 !== 5'b0) begin
            failures++;
            $display("FAIL %s dut1 outputs got=%b exp=00000", tag, o1);
        end
    endtask

    task automatic hold(input logic v, input int n);
        key = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero(tag);
    endtask

    initial begin
        int  len;
        bit  v;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_zero("reset");

        hold(1'b0, 5);
        // clean press
        hold(1'b1, 8);
        hold(1'b0, 10);
        // bounce
        hold(1'b1, 2);
        hold(1'b0, 1);
        hold(1'b1, 2);
        hold(1'b0, 10);
        // auto-repeat
        hold(1'b1, 30);
        hold(1'b0, 10);
        // release glitch while in HELD
        hold(1'b1, 12);
        hold(1'b0, 2);
        hold(1'b1, 20);
        hold(1'b0, 10);
        // long hold, where the repeat-disabled instance must stay silent
        hold(1'b1, 40);
        hold(1'b0, 10);
        // reset while repeating with the key still down
        hold(1'b1, 20);
        pulse_reset("reset_mid_hold");
        hold(1'b1, 15);
        hold(1'b0, 10);

        v = 1'b0;
        for (int i = 0; i < 60; i++) begin
            v   = ~v;
            len = int'($urandom_range(1, 14));
            hold(v, len);
            if ($urandom_range(0, 19) == 0) pulse_reset("reset_random");
        end
        hold(1'b0, 20);

        @(posedge clk);
        #2;
        checks++;
        if (q0.size() != 0) begin
            failures++;
            $display("FAIL drain dut0 got=%0d pending exp=0", q0.size());
        end
        checks++;
        if (q1.size() != 0) begin
            failures++;
            $display("FAIL drain dut1 got=%0d pending exp=0", q1.size());
        end
        checks++;
        if (rep1 != 0) begin
            failures++;
            $display("FAIL no_repeat dut1 got=%0d repeats exp=0", rep1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Conditions one raw push-button or key input for the game's control path. It synchronises the input into the clock domain and debounces it. It then emits clean single-cycle event pulses: press, release, and optional auto-repeat while held. It sits directly upstream of the pulse-stretching hold stage: `key_pulse` drives that stage's `signal_in`, and `key_level` feeds logic that needs the steady button state.

## Interface
- `DEBOUNCE_TIME`, 650000: cycles the synchronised input must stay stable before a press or release is accepted (10 ms at 65 MHz); ≥1.
- `REPEAT_EN`, 1: 1 enables auto-repeat while held; 0 disables it.
- `REPEAT_DELAY`, 32500000: cycles from accepted press to first repeat (0.5 s); ≥1.
- `REPEAT_PERIOD`, 6500000: cycles between subsequent repeats (0.1 s); ≥1.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `key_in`  in  1  raw asynchronous button level, 1 = pressed.
- `key_level`  out  1  debounced level, 1 = pressed.
- `key_press`  out  1  one-cycle pulse on each accepted press.
- `key_release`  out  1  one-cycle pulse on each accepted release.
- `key_repeat`  out  1  one-cycle pulse on each auto-repeat event.
- `key_pulse`  out  1  `key_press` OR `key_repeat`, registered, same cycle as its source.

## Operation
- **Synchroniser:** two flip-flops produce `key_sync`. Both reset to 0.
- **Counter:** one 26-bit counter is shared by all states. Every parameter must be < 2^26.
- **FSM states:** IDLE, PRESS_CHK, HELD, REPEAT, RELEASE_CHK. Reset state is IDLE.
- **IDLE:**
  - `key_sync`=1 → PRESS_CHK, counter←0.
- **PRESS_CHK:**
  - `key_sync`=0 → IDLE, with no output.
  - Else if counter==DEBOUNCE_TIME-1 → HELD, counter←0. Assert `key_press`/`key_pulse` for one cycle and set `key_level`←1.
  - Else counter+1.
- **HELD:**
  - `key_sync`=0 → RELEASE_CHK, counter←0.
  - Else if REPEAT_EN and counter==REPEAT_DELAY-1 → REPEAT, counter←0, with one-cycle `key_repeat`/`key_pulse`.
  - Else counter+1. The counter saturates when REPEAT_EN=0.
- **REPEAT:**
  - `key_sync`=0 → RELEASE_CHK, counter←0.
  - Else if counter==REPEAT_PERIOD-1 → one-cycle `key_repeat`/`key_pulse`, counter←0, stay in REPEAT.
  - Else counter+1.
- **RELEASE_CHK:**
  - `key_sync`=1 → HELD, counter←0. No new press is reported, and the repeat timing restarts from REPEAT_DELAY.
  - Else if counter==DEBOUNCE_TIME-1 → IDLE. Assert one-cycle `key_release` and set `key_level`←0.
  - Else counter+1.
- **Outputs:** all outputs are registered; their next values are decoded from the current state and inputs.
- **Reset values:** every output resets to 0 and the FSM returns to IDLE.
- **Reset mid-operation:** any pending or held press is discarded without a `key_release`. A key still held after reset is re-debounced from scratch and reported as a fresh press.
- **Mutual exclusion:** `key_press`, `key_release` and `key_repeat` are never high in the same cycle.

## Timing
- **Press latency:** let edge k be the first edge that samples `key_in`=1, with the input then held stable. `key_press` is high in the cycle after edge k+2+DEBOUNCE_TIME.
- **Release latency:** measured the same way from the first edge that samples 0, `key_release` is high in the cycle after edge k+2+DEBOUNCE_TIME.
- **Repeat timing:** the first `key_repeat` comes REPEAT_DELAY edges after `key_press`. Subsequent repeats come every REPEAT_PERIOD edges.
- **Glitch rejection:** a bounce shorter than DEBOUNCE_TIME cycles, in either direction, produces no event and leaves `key_level` unchanged.
- **No handshake:** pulses are fire-and-forget. The downstream hold stage is responsible for stretching them.

## Structure
- The FSM state encodings are local parameters inside the module.
- The default timing constants for the 65 MHz system clock (debounce, repeat delay, repeat period) go in the shared game constants header. This lets every button instance and the hold stage use the same values.
- One natural sub-module: `sync_2ff`, a 1-bit two-flop synchroniser with synchronous active-high reset. It is reusable for the other asynchronous inputs.

## Test plan
Bench parameters for all scenarios: DEBOUNCE_TIME=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=1.
- **Clean press:** `key_in` rises at edge k and is held 8 cycles, then released. Required: `key_press`=`key_pulse`=1 only after edge k+6, `key_level` rises at the same time, and `key_release` follows 6 edges after the first low sample.
- **Bounce:** `key_in` pulses high for 2 cycles, low for 1, high for 2, then low. Required: no pulse on any output, and `key_level` stays 0.
- **Auto-repeat:** hold for 30 cycles. Required: `key_press` at edge P, then `key_repeat`/`key_pulse` at P+10, P+13, P+16, P+19, …, and never coinciding with `key_press`.
- **Release glitch while held:** drop `key_in` for 2 cycles in HELD. Required: no `key_release` and no second `key_press`; `key_level` stays 1; the first repeat comes 10 edges after re-entering HELD.
- **Reset mid-hold:** assert `rst` for 1 cycle while in REPEAT with the key still held. Required: all outputs 0 on the next cycle, then a fresh `key_press` 6 edges after the first post-reset sample.
- **REPEAT_EN=0 variant:** hold for 40 cycles. Required: exactly one `key_press`, zero `key_repeat`, and one `key_release` after the key is let go.
